// File: rtl/inta_cycle_gen.sv
// inta_cycle_gen: 8088-style interrupt-acknowledge initiator.
// Watches the PIC INT line, runs the two-pulse INTA_n handshake with
// programmable pulse/gap widths, captures the vector byte on the second
// pulse and offers it (plus its IVT address) to the core until acknowledged.
module inta_cycle_gen #(
  parameter int unsigned INTA_LOW_CYCLES = 4,
  parameter int unsigned INTA_GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int_req,
  input  logic        if_en,
  input  logic [7:0]  pic_dout,
  output logic        inta_n,
  output logic        busy,
  output logic [7:0]  vector,
  output logic [19:0] vec_addr,
  output logic        vector_valid,
  input  logic        vector_ack
);

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    HOLD
  } state_t;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] LOW_LOAD = 8'(INTA_LOW_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD = 8'(INTA_GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        inta_n_d;
  logic        busy_d;
  logic [7:0]  vector_d;
  logic [19:0] vec_addr_d;
  logic        valid_d;

  // Next-state and next-output logic; every output is registered below,
  // so inta_n only ever changes on a clock edge tied to a state transition.
  always_comb begin
    // NOTE: every signal gets a hold-value default before the case so no
    // path leaves it unassigned; that is what keeps this block latch-free.
    state_d  = state_q;
    cnt_d    = cnt_q;
    inta_n_d = inta_n;
    busy_d   = busy;
    vector_d = vector;
    valid_d  = vector_valid;

    case (state_q)
      IDLE: begin
        if (int_req && if_en) begin
          state_d  = ACK1;
          inta_n_d = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = LOW_LOAD;
        end
      end

      // First pulse: the PIC freezes its priority logic; data bus ignored.
      ACK1: begin
        if (cnt_q == 8'd0) begin
          state_d  = GAP;
          inta_n_d = 1'b1;
          cnt_d    = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d  = ACK2;
          inta_n_d = 1'b0;
          cnt_d    = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      // Second pulse: the vector is sampled on the last low cycle.
      ACK2: begin
        if (cnt_q == 8'd0) begin
          state_d  = HOLD;
          inta_n_d = 1'b1;
          vector_d = pic_dout;
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      // Vector stays presented until the core takes it.
      HOLD: begin
        if (vector_ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        inta_n_d = 1'b1;
        busy_d   = 1'b0;
        valid_d  = 1'b0;
        cnt_d    = 8'd0;
      end
    endcase
  end

  // IVT entries are 4 bytes each, so the address is the vector times four.
  assign vec_addr_d = {10'b0, vector_d, 2'b00};

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      inta_n       <= 1'b1;
      busy         <= 1'b0;
      vector       <= 8'h00;
      vec_addr     <= 20'h0;
      vector_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inta_n       <= inta_n_d;
      busy         <= busy_d;
      vector       <= vector_d;
      vec_addr     <= vec_addr_d;
      vector_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_inta_cycle_gen.sv
// tb_inta_cycle_gen: directed scenarios followed by random traffic.
// A transaction-level model tracks time since the accepted request; each
// captured vector is queued and a monitor pops it when vector_valid rises.
module tb_inta_cycle_gen;

  localparam int L   = 4;
  localparam int G   = 2;
  localparam int LAT = 2 * L + G;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        int_req;
  logic        if_en;
  logic [7:0]  pic_dout;
  logic        vector_ack;
  logic        inta_n;
  logic        busy;
  logic [7:0]  vector;
  logic [19:0] vec_addr;
  logic        vector_valid;

  inta_cycle_gen #(
    .INTA_LOW_CYCLES(L),
    .INTA_GAP_CYCLES(G)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .int_req      (int_req),
    .if_en        (if_en),
    .pic_dout     (pic_dout),
    .inta_n       (inta_n),
    .busy         (busy),
    .vector       (vector),
    .vec_addr     (vec_addr),
    .vector_valid (vector_valid),
    .vector_ack   (vector_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  vec;
    logic [19:0] addr;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: a request opens a window of LAT cycles; inta_n is low
  // during the first L and the last L of that window.
  int         cyc    = 0;
  bit         m_init = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_valid = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_vec  = 8'h00;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_init  = 1'b1;
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_t     = 0;
        m_vec   = 8'h00;
        sb_q.delete();
      end else if (m_init) begin
        if (!m_busy) begin
          if (int_req && if_en) begin
            m_busy = 1'b1;
            m_t    = 0;
          end
        end else if (!m_valid) begin
          m_t++;
          if (m_t == LAT) begin
            exp_t e;
            m_valid = 1'b1;
            m_vec   = pic_dout;
            e.vec   = pic_dout;
            e.addr  = 20'(pic_dout) * 20'd4;
            e.cyc   = cyc;
            sb_q.push_back(e);
          end
        end else if (vector_ack) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
        end
      end
    end
  end

  // Monitor: cycle-level comparison of all outputs, plus scoreboard pop on
  // every rising edge of vector_valid.
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (m_init) begin
      logic exp_inta;
      exp_inta = !(m_busy && !m_valid && ((m_t < L) || (m_t >= L + G && m_t < LAT)));
      check("inta_n", 32'(inta_n), 32'(exp_inta));
      check("busy", 32'(busy), 32'(m_busy));
      check("vector_valid", 32'(vector_valid), 32'(m_valid));
      check("vector_held", 32'(vector), 32'(m_vec));
      check("vec_addr_held", 32'(vec_addr), 32'(m_vec) * 4);
      if (vector_valid === 1'b1 && prev_valid !== 1'b1) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_vector", 32'(vector), 32'(e.vec));
          check("sb_vec_addr", 32'(vec_addr), 32'(e.addr));
          check("sb_latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_valid = vector_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_model_valid(input string name);
    int k;
    k = 0;
    while (!m_valid && k < 40) begin
      tick(1);
      k++;
    end
    check(name, 32'(m_valid), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    int_req    = 1'b0;
    if_en      = 1'b0;
    pic_dout   = 8'h00;
    vector_ack = 1'b0;
    tick(3);
    check("reset_inta_n", 32'(inta_n), 32'd1);
    check("reset_vector", 32'(vector), 32'h00);
    rst_n = 1'b1;

    // Idle after reset release.
    tick(50);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic sequence with the PIC driving 8'h08.
    pic_dout = 8'h08;
    int_req  = 1'b1;
    if_en    = 1'b1;
    tick(1);
    check("s2_inta_low", 32'(inta_n), 32'd0);
    tick(1);
    int_req = 1'b0;
    wait_model_valid("s2_model_done");
    check("s2_valid", 32'(vector_valid), 32'd1);
    check("s2_vector", 32'(vector), 32'h08);
    check("s2_vec_addr", 32'(vec_addr), 32'h00020);
    vector_ack = 1'b1;
    tick(1);
    vector_ack = 1'b0;
    tick(3);

    // Request masked by IF, then unmasked.
    if_en   = 1'b0;
    int_req = 1'b1;
    tick(20);
    check("s3_masked_busy", 32'(busy), 32'd0);
    if_en    = 1'b1;
    pic_dout = 8'h0F;
    tick(1);
    check("s3_start", 32'(inta_n), 32'd0);
    // Request drops inside ACK1; the sequence must still complete.
    tick(1);
    int_req = 1'b0;
    wait_model_valid("s4_model_done");
    check("s4_vector", 32'(vector), 32'h0F);
    check("s4_vec_addr", 32'(vec_addr), 32'h0003C);

    // Long hold, then a one-cycle ack with the request still present.
    tick(30);
    check("s5_hold_valid", 32'(vector_valid), 32'd1);
    check("s5_hold_vector", 32'(vector), 32'h0F);
    int_req    = 1'b1;
    vector_ack = 1'b1;
    tick(1);
    vector_ack = 1'b0;
    check("s5_ack_valid", 32'(vector_valid), 32'd0);
    check("s5_idle_busy", 32'(busy), 32'd0);
    tick(1);
    check("s5_restart", 32'(inta_n), 32'd0);
    int_req = 1'b0;

    // Reset during GAP.
    tick(L);
    rst_n = 1'b0;
    tick(1);
    check("s6_gap_inta_n", 32'(inta_n), 32'd1);
    check("s6_gap_valid", 32'(vector_valid), 32'd0);
    check("s6_gap_vector", 32'(vector), 32'h00);
    rst_n   = 1'b1;
    int_req = 1'b1;
    tick(1);
    int_req = 1'b0;
    // Reset during ACK2.
    tick(L + G + 1);
    check("s6_in_ack2", 32'(inta_n), 32'd0);
    rst_n = 1'b0;
    tick(1);
    check("s6_ack2_inta_n", 32'(inta_n), 32'd1);
    check("s6_ack2_vector", 32'(vector), 32'h00);
    rst_n = 1'b1;
    tick(15);
    check("s6_no_stale", 32'(vector_valid), 32'd0);

    // Random traffic: pic_dout changes every cycle, so only the capture
    // cycle's value may end up in vector.
    for (int i = 0; i < 3000; i++) begin
      int_req    = ($urandom_range(0, 99) < 50);
      if_en      = ($urandom_range(0, 99) < 70);
      vector_ack = ($urandom_range(0, 99) < 30);
      pic_dout   = 8'($urandom);
      rst_n      = ($urandom_range(0, 299) != 0);
      tick(1);
    end

    // Drain and confirm nothing is left outstanding.
    rst_n      = 1'b1;
    int_req    = 1'b0;
    vector_ack = 1'b1;
    tick(25);
    check("drain_idle", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
